add_tc_16_pipe: RTL
===================

ADD_TC_16_PIPE -- requirements
Module: add_tc_16_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width; only 16 is supported.
REQ-002 SHALL have parameter GROUP, default 4, lookahead group size; WIDTH/GROUP groups.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand set valid.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 a  input  16  two's-complement operand A.
REQ-008 b  input  16  two's-complement operand B.
REQ-009 sub  input  1  0 = A+B, 1 = A-B.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 sum  output  16  result.
REQ-013 c_out  output  1  carry out of bit 15 (for sub: 1 = no borrow).
REQ-014 ovf  output  1  signed overflow.
REQ-015 zero  output  1  sum == 0.
REQ-016 op_count  output  8  count of completed output handshakes.

Function
REQ-017 Input handshake: transfer when in_valid && in_ready; output handshake: transfer when out_valid && out_ready.
REQ-018 Stage 1 on input transfer: register b_eff = sub ? ~b : b, c_in = sub, per-bit p = a^b_eff, g = a&b_eff, per-group pm/gm, a[15], b_eff[15].
REQ-019 Stage 2 on advance: group carries via lookahead from registered pm/gm and c_in, per-bit sums, flags; registered into output.
REQ-020 Latency: result of an operand accepted in cycle N appears with out_valid in cycle N+2 when unstalled; throughput one op per cycle.
REQ-021 s2_adv = !out_valid || out_ready; s1_adv = s1_valid && s2_adv; in_ready = !s1_valid || s2_adv (combinational, no dependence on in_valid).
REQ-022 Stall: outputs sum/c_out/ovf/zero SHALL hold stable while out_valid && !out_ready; no operand lost, duplicated or reordered.
REQ-023 Simultaneous output handshake and stage-1 advance SHALL replace the output in the same cycle without a bubble.
REQ-024 ovf = (a[15] == b_eff[15]) && (raw_sum[15] != a[15]).
REQ-025 zero computed on final sum (after saturation if compiled in).
REQ-026 op_count increments by 1 per output handshake, wraps 0xFF -> 0x00.

Reset
REQ-027 On rst: s1_valid=0, out_valid=0, sum=0, c_out=0, ovf=0, zero=0, op_count=0; in_ready=1 the following cycle.
REQ-028 Reset mid-operation SHALL discard all in-flight operands; no output handshake occurs in the reset cycle.

Configuration
REQ-029 Macro ADD_TC_SAT_EN: when defined, ovf with a[15]=0 forces sum=16'h7FFF, ovf with a[15]=1 forces sum=16'h8000; ovf and c_out still reflect the raw result.
REQ-030 Without ADD_TC_SAT_EN, sum is the raw wrapped result.

Structure
REQ-031 Package add_tc_pkg SHALL hold WIDTH, GROUP, NGROUP, SAT_POS (16'h7FFF), SAT_NEG (16'h8000) and the stage-1 register struct (p, g, pm, gm, c_in, a_msb, b_msb).
REQ-032 Sub-module pg4_gen SHALL produce per-bit p/g and group pm/gm for one 4-bit slice; instantiated NGROUP times in stage 1.

Verification
REQ-033 0x7FFF + 0x0001 -> sum 0x8000, ovf=1, c_out=0, zero=0; with ADD_TC_SAT_EN sum 0x7FFF.
REQ-034 0x8000 - 0x0001 -> sum 0x7FFF, ovf=1, c_out=1; with ADD_TC_SAT_EN sum 0x8000.
REQ-035 0x0005 - 0x0005 -> sum 0x0000, zero=1, c_out=1, ovf=0; 0xFFFF + 0x0001 -> sum 0x0000, c_out=1, zero=1, ovf=0.
REQ-036 Four back-to-back ops, out_ready low for 3 cycles after first out_valid -> in_ready drops once both stages full, four results delivered in order, op_count=4.
REQ-037 rst asserted with both stages valid -> next cycle out_valid=0, in_ready=1, op_count=0; next op completes with latency 2.
REQ-038 256 continuous handshakes from reset -> op_count returns to 0x00.

Source files
------------

// File: rtl/add_tc_pkg.sv
// Shared widths, saturation limits and the stage-1 register bundle for the
// pipelined two's-complement adder (saturation enabled by ADD_TC_SAT_EN).
package add_tc_pkg;

   localparam int WIDTH  = 16;
   localparam int GROUP  = 4;
   localparam int NGROUP = WIDTH / GROUP;

   localparam logic [WIDTH-1:0] SAT_POS = 16'h7FFF;
   localparam logic [WIDTH-1:0] SAT_NEG = 16'h8000;

   typedef struct packed {
      logic [WIDTH-1:0]  p;
      logic [WIDTH-1:0]  g;
      logic [NGROUP-1:0] pm;
      logic [NGROUP-1:0] gm;
      logic              c_in;
      logic              a_msb;
      logic              b_msb;
   } s1_t;

endpackage

// File: rtl/pg4_gen.sv
// Per-bit propagate/generate and group propagate/generate for one
// 4-bit lookahead slice.
module pg4_gen
   import add_tc_pkg::*;
(
   input  logic [GROUP-1:0] a,
   input  logic [GROUP-1:0] b,
   output logic [GROUP-1:0] p,
   output logic [GROUP-1:0] g,
   output logic             pm,
   output logic             gm
);

   assign p  = a ^ b;
   assign g  = a & b;
   assign pm = &p;
   assign gm = g[3]
             | (p[3] & g[2])
             | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/add_tc_16_pipe.sv
// Two-stage valid/ready 16-bit add/sub with 4-bit carry lookahead groups.
// Define ADD_TC_SAT_EN to saturate the sum on signed overflow.
module add_tc_16_pipe
   import add_tc_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int GROUP = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf,
   output logic             zero,
   output logic [7:0]       op_count
);

   logic             s1_valid;
   s1_t              s1_q;
   logic             s1_adv;
   logic             s2_adv;
   logic             in_fire;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] p_w;
   logic [WIDTH-1:0] g_w;
   logic [NGROUP-1:0] pm_w;
   logic [NGROUP-1:0] gm_w;
   logic [WIDTH-1:0] raw;
   logic [WIDTH-1:0] sum_w;
   logic             cout_w;
   logic             ovf_w;
   logic             zero_w;

   assign s2_adv   = !out_valid || out_ready;
   assign s1_adv   = s1_valid && s2_adv;
   assign in_ready = !s1_valid || s2_adv;
   assign in_fire  = in_valid && in_ready;
   assign b_eff    = sub ? ~b : b;

   for (genvar i = 0; i < NGROUP; i++) begin : g_pg
      pg4_gen u_pg (
         .a  (a[i*GROUP +: GROUP]),
         .b  (b_eff[i*GROUP +: GROUP]),
         .p  (p_w[i*GROUP +: GROUP]),
         .g  (g_w[i*GROUP +: GROUP]),
         .pm (pm_w[i]),
         .gm (gm_w[i])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_q     <= '0;
      end else if (in_fire) begin
         s1_valid   <= 1'b1;
         s1_q.p     <= p_w;
         s1_q.g     <= g_w;
         s1_q.pm    <= pm_w;
         s1_q.gm    <= gm_w;
         s1_q.c_in  <= sub;
         s1_q.a_msb <= a[WIDTH-1];
         s1_q.b_msb <= b_eff[WIDTH-1];
      end else if (s1_adv) begin
         s1_valid <= 1'b0;
      end
   end

   // Group carries come from lookahead; bits inside a group ripple from
   // their group carry-in.
   always_comb begin
      logic cg;
      logic cb;
      raw    = '0;
      cg     = s1_q.c_in;
      for (int k = 0; k < NGROUP; k++) begin
         cb = cg;
         for (int j = 0; j < GROUP; j++) begin
            raw[k*GROUP+j] = s1_q.p[k*GROUP+j] ^ cb;
            cb = s1_q.g[k*GROUP+j] | (s1_q.p[k*GROUP+j] & cb);
         end
         cg = s1_q.gm[k] | (s1_q.pm[k] & cg);
      end
      cout_w = cg;
      ovf_w  = (s1_q.a_msb == s1_q.b_msb)
            && (raw[WIDTH-1] != s1_q.a_msb);
`ifdef ADD_TC_SAT_EN
      if (ovf_w)
         sum_w = s1_q.a_msb ? SAT_NEG : SAT_POS;
      else
         sum_w = raw;
`else
      sum_w = raw;
`endif
      zero_w = (sum_w == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         sum       <= '0;
         c_out     <= 1'b0;
         ovf       <= 1'b0;
         zero      <= 1'b0;
         op_count  <= 8'd0;
      end else begin
         if (s2_adv)
            out_valid <= s1_valid;
         if (s1_adv) begin
            sum   <= sum_w;
            c_out <= cout_w;
            ovf   <= ovf_w;
            zero  <= zero_w;
         end
         if (out_valid && out_ready)
            op_count <= op_count + 8'd1;
      end
   end

endmodule
